anti_theft_controller: RTL and testbench

- Security FSM for the automotive anti-theft system. It watches the ignition and the two door switches and arms itself after the driver leaves.
- When an armed car is entered, it runs an entry countdown and then sounds the siren. It drives the status LED.
- Its `armed` output is the arming status that the system's fuel-pump gating stage consumes.
- All delays are counted in pulses of a shared 1 Hz tick enable.

---
 rtl/anti_theft_if.sv | 20 ++
 rtl/anti_theft_controller.sv | 99 +++++++++
 tb/tb_anti_theft_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/anti_theft_if.sv
// Sensor inputs and indicator outputs of the anti-theft controller.
interface anti_theft_if;
    logic       one_hz_en;
    logic       ignition;
    logic       door_driver;
    logic       door_passenger;
    logic       siren;
    logic       status_led;
    logic       armed;
    logic [2:0] state_out;

    modport master (
        output one_hz_en, ignition, door_driver, door_passenger,
        input  siren, status_led, armed, state_out
    );
    modport slave (
        input  one_hz_en, ignition, door_driver, door_passenger,
        output siren, status_led, armed, state_out
    );
endinterface

// File: rtl/anti_theft_controller.sv
// Anti-theft FSM: arms after the driver leaves, runs an entry countdown on
// intrusion, then sounds the siren. All delays count 1 Hz tick enables.
module anti_theft_controller #(
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10,
    parameter int CNT_W             = 4
) (
    input  logic          clock,
    input  logic          reset,
    anti_theft_if.slave   bus
);
    typedef enum logic [2:0] {
        ARMED           = 3'd0,
        TRIGGERED       = 3'd1,
        SOUND_ALARM     = 3'd2,
        DISARMED        = 3'd3,
        WAIT_DOOR_OPEN  = 3'd4,
        WAIT_DOOR_CLOSE = 3'd5,
        ARM_DELAY       = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LD_ARM   = CNT_W'(T_ARM_DELAY);
    localparam logic [CNT_W-1:0] LD_DRV   = CNT_W'(T_DRIVER_DELAY);
    localparam logic [CNT_W-1:0] LD_PAS   = CNT_W'(T_PASSENGER_DELAY);
    localparam logic [CNT_W-1:0] LD_ALARM = CNT_W'(T_ALARM_ON);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             blink, blink_nxt;
    logic             expire, door_any;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARMED;
            cnt   <= '0;
            blink <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            blink <= blink_nxt;
        end
    end

    // Timed transition fires on the tick that finds cnt at 1.
    assign expire   = bus.one_hz_en && (cnt == CNT_W'(1));
    assign door_any = bus.door_driver | bus.door_passenger;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ARMED: begin
                if (bus.ignition)            state_nxt = DISARMED;
                else if (bus.door_driver)    begin state_nxt = TRIGGERED; cnt_nxt = LD_DRV; end
                else if (bus.door_passenger) begin state_nxt = TRIGGERED; cnt_nxt = LD_PAS; end
            end
            TRIGGERED: begin
                if (bus.ignition)  state_nxt = DISARMED;
                else if (expire)   begin state_nxt = SOUND_ALARM; cnt_nxt = LD_ALARM; end
                else if (bus.one_hz_en) cnt_nxt = cnt - CNT_W'(1);
            end
            SOUND_ALARM: begin
                if (bus.ignition)  state_nxt = DISARMED;
                else if (door_any) cnt_nxt = LD_ALARM;
                else if (expire)   state_nxt = ARMED;
                else if (bus.one_hz_en) cnt_nxt = cnt - CNT_W'(1);
            end
            DISARMED: begin
                if (!bus.ignition) state_nxt = WAIT_DOOR_OPEN;
            end
            WAIT_DOOR_OPEN: begin
                if (bus.ignition)         state_nxt = DISARMED;
                else if (bus.door_driver) state_nxt = WAIT_DOOR_CLOSE;
            end
            WAIT_DOOR_CLOSE: begin
                if (bus.ignition)          state_nxt = DISARMED;
                else if (!bus.door_driver) begin state_nxt = ARM_DELAY; cnt_nxt = LD_ARM; end
            end
            ARM_DELAY: begin
                if (bus.ignition)  state_nxt = DISARMED;
                else if (door_any) state_nxt = WAIT_DOOR_CLOSE;
                else if (expire)   state_nxt = ARMED;
                else if (bus.one_hz_en) cnt_nxt = cnt - CNT_W'(1);
            end
            default: state_nxt = ARMED;
        endcase
    end

    // Blink only runs while staying in ARMED; any exit or entry starts it from 0.
    assign blink_nxt = (state == ARMED && state_nxt == ARMED) ? (blink ^ bus.one_hz_en) : 1'b0;

    assign bus.siren      = (state == SOUND_ALARM);
    assign bus.armed      = (state == ARMED) || (state == TRIGGERED) || (state == SOUND_ALARM);
    assign bus.status_led = (state == ARMED) ? blink
                          : ((state == TRIGGERED) || (state == SOUND_ALARM));
    assign bus.state_out  = state;
endmodule

// File: tb/tb_anti_theft_controller.sv
// Directed self-checking bench for anti_theft_controller.
module tb_anti_theft_controller;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    anti_theft_if bus ();

    anti_theft_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        bus.one_hz_en = 1'b1;
        step();
        bus.one_hz_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (bus.state_out !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.state_out); end
        n_cmp++; if (bus.armed !== 1'b1) begin n_err++; $display("FAIL reset_armed: got %b want 1", bus.armed); end
        n_cmp++; if (bus.siren !== 1'b0 || bus.status_led !== 1'b0) begin n_err++; $display("FAIL reset_outputs: siren %b led %b want 0 0", bus.siren, bus.status_led); end
        tick();
        n_cmp++; if (bus.status_led !== 1'b1) begin n_err++; $display("FAIL blink_1: got %b want 1", bus.status_led); end
        tick();
        n_cmp++; if (bus.status_led !== 1'b0) begin n_err++; $display("FAIL blink_2: got %b want 0", bus.status_led); end
        tick();
        n_cmp++; if (bus.status_led !== 1'b1 || bus.state_out !== 3'd0) begin n_err++; $display("FAIL blink_3: led %b state %0d want 1 0", bus.status_led, bus.state_out); end
    endtask

    task automatic test_driver_alarm();
        bus.door_driver = 1'b1;
        step();
        bus.door_driver = 1'b0;
        n_cmp++; if (bus.state_out !== 3'd1 || bus.status_led !== 1'b1) begin n_err++; $display("FAIL drv_trig: state %0d led %b want 1 1", bus.state_out, bus.status_led); end
        ticks(7);
        n_cmp++; if (bus.state_out !== 3'd1) begin n_err++; $display("FAIL drv_tick7: got %0d want 1", bus.state_out); end
        tick();
        n_cmp++; if (bus.state_out !== 3'd2 || bus.siren !== 1'b1) begin n_err++; $display("FAIL drv_alarm: state %0d siren %b want 2 1", bus.state_out, bus.siren); end
        ticks(9);
        n_cmp++; if (bus.state_out !== 3'd2) begin n_err++; $display("FAIL alarm_tick9: got %0d want 2", bus.state_out); end
        tick();
        n_cmp++; if (bus.state_out !== 3'd0 || bus.siren !== 1'b0 || bus.status_led !== 1'b0) begin n_err++; $display("FAIL alarm_end: state %0d siren %b led %b want 0 0 0", bus.state_out, bus.siren, bus.status_led); end
    endtask

    task automatic test_passenger_disarm();
        logic siren_seen;
        siren_seen = 1'b0;
        bus.door_passenger = 1'b1;
        step();
        bus.door_passenger = 1'b0;
        n_cmp++; if (bus.state_out !== 3'd1) begin n_err++; $display("FAIL pas_trig: got %0d want 1", bus.state_out); end
        for (int i = 0; i < 14; i++) begin
            tick();
            siren_seen = siren_seen | bus.siren;
        end
        n_cmp++; if (bus.state_out !== 3'd1) begin n_err++; $display("FAIL pas_tick14: got %0d want 1", bus.state_out); end
        bus.ignition = 1'b1;
        step();
        siren_seen = siren_seen | bus.siren;
        n_cmp++; if (bus.state_out !== 3'd3 || bus.armed !== 1'b0 || bus.status_led !== 1'b0) begin n_err++; $display("FAIL pas_disarm: state %0d armed %b led %b want 3 0 0", bus.state_out, bus.armed, bus.status_led); end
        n_cmp++; if (siren_seen !== 1'b0) begin n_err++; $display("FAIL pas_siren: got %b want 0", siren_seen); end
    endtask

    task automatic test_arm_sequence();
        bus.ignition = 1'b0;
        step();
        n_cmp++; if (bus.state_out !== 3'd4) begin n_err++; $display("FAIL arm_wait_open: got %0d want 4", bus.state_out); end
        bus.door_passenger = 1'b1;
        step();
        bus.door_passenger = 1'b0;
        n_cmp++; if (bus.state_out !== 3'd4) begin n_err++; $display("FAIL arm_pas_ignored: got %0d want 4", bus.state_out); end
        bus.door_driver = 1'b1;
        step();
        n_cmp++; if (bus.state_out !== 3'd5) begin n_err++; $display("FAIL arm_wait_close: got %0d want 5", bus.state_out); end
        bus.door_driver = 1'b0;
        step();
        n_cmp++; if (bus.state_out !== 3'd6) begin n_err++; $display("FAIL arm_delay: got %0d want 6", bus.state_out); end
        ticks(3);
        bus.door_driver = 1'b1;
        step();
        n_cmp++; if (bus.state_out !== 3'd5) begin n_err++; $display("FAIL arm_reopen: got %0d want 5", bus.state_out); end
        bus.door_driver = 1'b0;
        step();
        n_cmp++; if (bus.state_out !== 3'd6) begin n_err++; $display("FAIL arm_reclose: got %0d want 6", bus.state_out); end
        ticks(5);
        n_cmp++; if (bus.state_out !== 3'd6 || bus.armed !== 1'b0) begin n_err++; $display("FAIL arm_tick5: state %0d armed %b want 6 0", bus.state_out, bus.armed); end
        tick();
        n_cmp++; if (bus.state_out !== 3'd0 || bus.armed !== 1'b1) begin n_err++; $display("FAIL arm_done: state %0d armed %b want 0 1", bus.state_out, bus.armed); end
    endtask

    task automatic test_both_doors();
        bus.door_driver    = 1'b1;
        bus.door_passenger = 1'b1;
        step();
        bus.door_driver    = 1'b0;
        bus.door_passenger = 1'b0;
        n_cmp++; if (bus.state_out !== 3'd1) begin n_err++; $display("FAIL both_trig: got %0d want 1", bus.state_out); end
        ticks(7);
        n_cmp++; if (bus.state_out !== 3'd1) begin n_err++; $display("FAIL both_tick7: got %0d want 1", bus.state_out); end
        tick();
        n_cmp++; if (bus.state_out !== 3'd2 || bus.siren !== 1'b1) begin n_err++; $display("FAIL both_alarm8: state %0d siren %b want 2 1", bus.state_out, bus.siren); end
        ticks(5);
        bus.door_passenger = 1'b1;
        step();
        tick();
        n_cmp++; if (bus.state_out !== 3'd2) begin n_err++; $display("FAIL reopen_hold: got %0d want 2", bus.state_out); end
        bus.door_passenger = 1'b0;
        step();
        ticks(9);
        n_cmp++; if (bus.state_out !== 3'd2 || bus.siren !== 1'b1) begin n_err++; $display("FAIL reopen_tick9: state %0d siren %b want 2 1", bus.state_out, bus.siren); end
        tick();
        n_cmp++; if (bus.state_out !== 3'd0 || bus.siren !== 1'b0) begin n_err++; $display("FAIL reopen_end: state %0d siren %b want 0 0", bus.state_out, bus.siren); end
    endtask

    task automatic test_reset_mid_alarm();
        bus.door_driver = 1'b1;
        step();
        bus.door_driver = 1'b0;
        ticks(8);
        n_cmp++; if (bus.state_out !== 3'd2) begin n_err++; $display("FAIL rst_pre_alarm: got %0d want 2", bus.state_out); end
        ticks(3);
        reset         = 1'b1;
        bus.one_hz_en = 1'b1;
        step();
        reset         = 1'b0;
        bus.one_hz_en = 1'b0;
        n_cmp++; if (bus.state_out !== 3'd0 || bus.siren !== 1'b0 || bus.status_led !== 1'b0) begin n_err++; $display("FAIL rst_mid: state %0d siren %b led %b want 0 0 0", bus.state_out, bus.siren, bus.status_led); end
        bus.door_driver = 1'b1;
        step();
        bus.door_driver = 1'b0;
        ticks(7);
        n_cmp++; if (bus.state_out !== 3'd1) begin n_err++; $display("FAIL rst_fresh7: got %0d want 1", bus.state_out); end
        tick();
        n_cmp++; if (bus.state_out !== 3'd2) begin n_err++; $display("FAIL rst_fresh8: got %0d want 2", bus.state_out); end
    endtask

    initial begin
        bus.one_hz_en      = 1'b0;
        bus.ignition       = 1'b0;
        bus.door_driver    = 1'b0;
        bus.door_passenger = 1'b0;
        step();
        test_reset();
        test_driver_alarm();
        test_passenger_disarm();
        test_arm_sequence();
        test_both_doors();
        test_reset_mid_alarm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
